// File: rtl/camera_stream_emulator.sv
// -----------------------------------------------------------------------------
// camera_stream_emulator
//
// Synthetic transmitter for the camera connector protocol. It produces the
// frame_val / line_val / pixel_data stream that the capture path normally
// receives from the D5M sensor, so the capture logic can be exercised
// without a physical camera. The emulated pixel clock is clk itself.
//
// Frame layout (frame_val high):
//   LEAD (H_BLANK) , { LINE (H_ACTIVE) , HBLANK (H_BLANK) } x (V_ACTIVE-1) ,
//   LINE (H_ACTIVE)
// followed by VBLANK (frame_val low) for V_BLANK line periods.
//
// Ports
//   clk          in   1       stream clock
//   reset_n      in   1       asynchronous reset, active low
//   enable       in   1       request frames; sampled in IDLE and at VBLANK exit
//   pattern_sel  in   2       0 x ramp, 1 y ramp, 2 8x8 checker, 3 Bayer solid
//   frame_val    out  1       FVAL
//   line_val     out  1       LVAL
//   pixel_data   out  DATA_W  pixel value, Bayer order, 0 outside active lines
//   frame_done   out  1       one-clock pulse on the first VBLANK clock
//   frame_count  out  16      frames completed, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module camera_stream_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int V_BLANK  = 45,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic              frame_val,
  output logic              line_val,
  output logic [DATA_W-1:0] pixel_data,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int LINE_PERIOD = H_ACTIVE + H_BLANK;
  localparam int VB_TOTAL    = V_BLANK * LINE_PERIOD;
  // One shared counter covers LEAD, LINE (as x), HBLANK and VBLANK; the
  // VBLANK total is always the largest of those spans.
  localparam int CNT_W       = $clog2(VB_TOTAL + 1);
  localparam int Y_W         = $clog2(V_ACTIVE + 1);

  localparam logic [CNT_W-1:0] HA_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VB_TOTAL - 1);
  localparam logic [Y_W-1:0]   VA_LAST = Y_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LINE,
    HBLANK,
    VBLANK
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [Y_W-1:0]   y_reg;
  logic [1:0]       pat_reg;

  // Pixel value for the active position (x, y) under the latched pattern.
  function automatic logic [DATA_W-1:0] pixel_value(
    input logic [1:0]  pat,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [DATA_W-1:0] val;
    val = '0;
    case (pat)
      2'd0: val = DATA_W'(x);
      2'd1: val = DATA_W'(y);
      2'd2: val = (((x ^ y) & 32'd8) != 32'd0) ? '1 : '0;
      default: begin
        // Bayer sites: even row G R G R ..., odd row B G B G ...
        if ((y & 32'd1) == 32'd0)
          val = ((x & 32'd1) != 32'd0) ? '1 : '0;
        else
          val = ((x & 32'd1) == 32'd0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
      end
    endcase
    return val;
  endfunction

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the cycle the new state begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      y_reg       <= '0;
      pat_reg     <= '0;
      frame_val   <= 1'b0;
      line_val    <= 1'b0;
      pixel_data  <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= LEAD;
            cnt_reg   <= '0;
            frame_val <= 1'b1;
            pat_reg   <= pattern_sel;
          end
        end

        LEAD: begin
          if (cnt_reg == HB_LAST) begin
            state_reg  <= LINE;
            cnt_reg    <= '0;
            y_reg      <= '0;
            line_val   <= 1'b1;
            pixel_data <= pixel_value(pat_reg, 32'd0, 32'd0);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        LINE: begin
          // cnt_reg is the x of the pixel currently on the bus.
          if (cnt_reg == HA_LAST) begin
            cnt_reg    <= '0;
            line_val   <= 1'b0;
            pixel_data <= '0;
            if (y_reg == VA_LAST) begin
              state_reg   <= VBLANK;
              frame_val   <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              state_reg <= HBLANK;
            end
          end else begin
            cnt_reg    <= cnt_reg + CNT_W'(1);
            pixel_data <= pixel_value(pat_reg, 32'(cnt_reg) + 32'd1, 32'(y_reg));
          end
        end

        HBLANK: begin
          if (cnt_reg == HB_LAST) begin
            state_reg  <= LINE;
            cnt_reg    <= '0;
            y_reg      <= y_reg + Y_W'(1);
            line_val   <= 1'b1;
            pixel_data <= pixel_value(pat_reg, 32'd0, 32'(y_reg) + 32'd1);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        VBLANK: begin
          if (cnt_reg == VB_LAST) begin
            cnt_reg <= '0;
            if (enable) begin
              state_reg <= LEAD;
              frame_val <= 1'b1;
              pat_reg   <= pattern_sel;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_stream_emulator.sv
// -----------------------------------------------------------------------------
// tb_camera_stream_emulator
//
// Self-checking bench for camera_stream_emulator with a small frame
// (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, V_BLANK=2). Expected pixels for each
// frame are pushed to a scoreboard queue when the frame is requested and
// popped as the DUT presents active pixels. Outputs are sampled on the
// falling edge of clk.
// -----------------------------------------------------------------------------
module tb_camera_stream_emulator;

  localparam int HA     = 8;
  localparam int VA     = 4;
  localparam int HB     = 3;
  localparam int VB     = 2;
  localparam int DW     = 12;
  localparam int FV_LEN = HB + VA * HA + (VA - 1) * HB;  // 44
  localparam int VB_LEN = VB * (HA + HB);                // 22
  localparam int IDLE_WATCH = 60;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [1:0]    pattern_sel;
  logic          frame_val;
  logic          line_val;
  logic [DW-1:0] pixel_data;
  logic          frame_done;
  logic [15:0]   frame_count;

  int            n_cmp;
  int            n_bad;
  int            exp_count;
  logic [DW-1:0] sb_q[$];

  camera_stream_emulator #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .H_BLANK (HB),
    .V_BLANK (VB),
    .DATA_W  (DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .frame_val  (frame_val),
    .line_val   (line_val),
    .pixel_data (pixel_data),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_pix(int pat, int x, int y);
    case (pat)
      0: return DW'(x);
      1: return DW'(y);
      2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
      default: begin
        if (y % 2 == 0) return (x % 2 == 1) ? 12'hFFF : 12'h000;
        else            return (x % 2 == 0) ? 12'h800 : 12'h000;
      end
    endcase
  endfunction

  // Expected line_val for the i-th clock of frame_val being high.
  function automatic logic exp_lv(int i);
    if (i < HB || i >= FV_LEN) return 1'b0;
    return ((i - HB) % (HA + HB)) < HA;
  endfunction

  // Starting at the first frame_val-high sample, walk the whole frame and
  // its vertical blanking. next_pat is applied mid-frame; drop_at >= 0
  // deasserts enable at that frame clock.
  task automatic observe_frame(input int pat, input int next_pat, input int drop_at);
    int            i;
    int            low;
    int            exp_low;
    logic [DW-1:0] exp;
    logic          lv_exp;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        sb_q.push_back(exp_pix(pat, x, y));
    i = 0;
    while (frame_val === 1'b1 && i < 200) begin
      if (i == drop_at) enable = 1'b0;
      if (i == 20) pattern_sel = next_pat[1:0];
      lv_exp = exp_lv(i);
      n_cmp++;
      if (line_val !== lv_exp) begin
        n_bad++;
        $display("FAIL line_val frame_clk=%0d got %b required %b", i, line_val, lv_exp);
      end
      if (line_val === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pixel_extra frame_clk=%0d got pixel %h required none", i, pixel_data);
        end else begin
          exp = sb_q.pop_front();
          n_cmp++;
          if (pixel_data !== exp) begin
            n_bad++;
            $display("FAIL pixel pat=%0d frame_clk=%0d got %h required %h", pat, i, pixel_data, exp);
          end
        end
      end else begin
        n_cmp++;
        if (pixel_data !== '0) begin
          n_bad++;
          $display("FAIL pixel_blank frame_clk=%0d got %h required 000", i, pixel_data);
        end
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
        n_bad++;
        $display("FAIL frame_done_early frame_clk=%0d got %b required 0", i, frame_done);
      end
      i++;
      @(negedge clk);
    end
    n_cmp++;
    if (i != FV_LEN) begin
      n_bad++;
      $display("FAIL fval_len got %0d required %0d", i, FV_LEN);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL pixel_count got %0d left over required 0", sb_q.size());
    end
    sb_q.delete();
    exp_count++;
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_done got %b required 1", frame_done);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_count)) begin
      n_bad++;
      $display("FAIL frame_count got %0d required %0d", frame_count, exp_count);
    end
    exp_low = enable ? VB_LEN : IDLE_WATCH;
    low = 0;
    while (frame_val === 1'b0 && low < IDLE_WATCH) begin
      if (low > 0) begin
        n_cmp++;
        if (frame_done !== 1'b0) begin
          n_bad++;
          $display("FAIL frame_done_width vblank_clk=%0d got %b required 0", low, frame_done);
        end
      end
      low++;
      @(negedge clk);
    end
    n_cmp++;
    if (low != exp_low) begin
      n_bad++;
      $display("FAIL vblank_len got %0d required %0d", low, exp_low);
    end
    $display("frame pat=%0d fval_clks=%0d low_clks=%0d frame_count=%0d", pat, i, low, frame_count);
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enable      = i[0];
      pattern_sel = i[2:1];
      n_cmp++;
      if ({frame_val, line_val, pixel_data, frame_done, frame_count} !== 30'd0) begin
        n_bad++;
        $display("FAIL reset_hold got fv=%b lv=%b px=%h fd=%b fc=%0d required all 0",
                 frame_val, line_val, pixel_data, frame_done, frame_count);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({frame_val, line_val, pixel_data, frame_done, frame_count} !== 30'd0) begin
        n_bad++;
        $display("FAIL idle_after_reset got fv=%b lv=%b px=%h fd=%b fc=%0d required all 0",
                 frame_val, line_val, pixel_data, frame_done, frame_count);
      end
    end
    $display("reset: outputs held at 0 during and after reset");
  endtask

  task automatic test_frame_timing();
    pattern_sel = 2'd0;
    enable      = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_val !== 1'b1) begin
      n_bad++;
      $display("FAIL fval_start got %b required 1", frame_val);
    end
    observe_frame(0, 1, -1);
  endtask

  task automatic test_patterns();
    observe_frame(1, 2, -1);
    observe_frame(2, 3, -1);
  endtask

  task automatic test_enable_drop();
    observe_frame(3, 0, 15);
  endtask

  task automatic test_reset_midframe();
    pattern_sel = 2'd3;
    enable      = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_val !== 1'b1) begin
      n_bad++;
      $display("FAIL fval_restart got %b required 1", frame_val);
    end
    // Frame clock 30 is line 2, x = 5: Bayer even row, odd column -> FFF.
    for (int k = 0; k < HB + 2 * (HA + HB) + 5; k++) @(negedge clk);
    n_cmp++;
    if (line_val !== 1'b1 || pixel_data !== 12'hFFF) begin
      n_bad++;
      $display("FAIL pre_reset_pixel got lv=%b px=%h required lv=1 px=FFF", line_val, pixel_data);
    end
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    n_cmp++;
    if ({frame_val, line_val, pixel_data, frame_done, frame_count} !== 30'd0) begin
      n_bad++;
      $display("FAIL async_reset got fv=%b lv=%b px=%h fd=%b fc=%0d required all 0",
               frame_val, line_val, pixel_data, frame_done, frame_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({frame_val, line_val, pixel_data, frame_done, frame_count} !== 30'd0) begin
        n_bad++;
        $display("FAIL no_resume got fv=%b lv=%b px=%h fd=%b fc=%0d required all 0",
                 frame_val, line_val, pixel_data, frame_done, frame_count);
      end
    end
    exp_count   = 0;
    pattern_sel = 2'd3;
    enable      = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_val !== 1'b1) begin
      n_bad++;
      $display("FAIL fval_after_reset got %b required 1", frame_val);
    end
    observe_frame(3, 1, 5);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_count = 0;
    test_reset();
    test_frame_timing();
    test_patterns();
    test_enable_drop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
